// File: rtl/trdb_branch_map_mr.sv
// ---------------------------------------------------------------------------
// trdb_branch_map_mr
//
// Multi-retire branch map for the trace encoder.
// Up to RETIRE_W branch outcomes are appended per cycle. A set bit means
// "not taken", and lane 0 is the oldest branch. When the live map fills, the
// completed map is moved into a one-entry valid/ready hand-off buffer. Any
// leftover branches from that cycle start a fresh live map, so the packet
// emitter can drain the snapshot without losing branches.
//
// Optional feature macro: BRANCH_PREDICT_EN
//   When defined, the ports predict_i and pbc_o are added. While the live map
//   is empty, correctly predicted branches are counted in pbc_o and are not
//   appended to the map.
//
// Ports
//   clk_i         clock
//   rst_i         asynchronous reset, active-high
//   valid_i       per-lane branch retired
//   taken_i       per-lane branch taken
//   predict_i     per-lane predicted taken            (BRANCH_PREDICT_EN)
//   pbc_o         predicted-branch counter, saturates (BRANCH_PREDICT_EN)
//   flush_i       live map consumed; clear it (acts this cycle)
//   map_o         live map
//   branches_o    live branch count, 0..MAP_LEN-1
//   empty_o       live count is zero
//   full_valid_o  completed map pending in the hand-off buffer
//   full_map_o    completed map snapshot
//   full_ready_i  emitter accepts the snapshot
//   overflow_o    sticky: a completed map was dropped (cleared by flush_i)
// ---------------------------------------------------------------------------
module trdb_branch_map_mr #(
    parameter int MAP_LEN  = 31,
    parameter int RETIRE_W = 2,
    parameter int PBC_W    = 16,
    localparam int CNT_W   = $clog2(MAP_LEN + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [RETIRE_W-1:0] valid_i,
    input  logic [RETIRE_W-1:0] taken_i,
`ifdef BRANCH_PREDICT_EN
    input  logic [RETIRE_W-1:0] predict_i,
    output logic [PBC_W-1:0]    pbc_o,
`endif
    input  logic                flush_i,
    output logic [MAP_LEN-1:0]  map_o,
    output logic [CNT_W-1:0]    branches_o,
    output logic                empty_o,
    output logic                full_valid_o,
    output logic [MAP_LEN-1:0]  full_map_o,
    input  logic                full_ready_i,
    output logic                overflow_o
);

    // The working map is wide enough to hold a nearly full map plus one
    // cycle of retired lanes, so the spill-over bits need no special case.
    localparam int EXT_W = MAP_LEN + RETIRE_W;

    logic [MAP_LEN-1:0] map_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               empty_q;
    logic               full_valid_q;
    logic [MAP_LEN-1:0] full_map_q;
    logic               overflow_q;

    logic [CNT_W:0]     base_cnt;
    logic [CNT_W:0]     sum_cnt;
    logic [EXT_W-1:0]   ext_map;
    logic               append_lane;
    logic               complete;
    logic [MAP_LEN-1:0] next_map;
    logic [CNT_W-1:0]   next_cnt;
    logic               accept;

`ifdef BRANCH_PREDICT_EN
    logic [PBC_W-1:0]   pbc_q;
    logic [PBC_W-1:0]   pbc_next;
    logic               hunting;
`endif

    // Lanes are compacted in lane order on top of the base map. A flush clears
    // the base in the same cycle, so this cycle's branches land at bit 0.
    always_comb begin
        base_cnt    = flush_i ? '0 : {1'b0, cnt_q};
        ext_map     = '0;
        ext_map[MAP_LEN-1:0] = flush_i ? '0 : map_q;
        sum_cnt     = base_cnt;
        append_lane = 1'b0;
`ifdef BRANCH_PREDICT_EN
        pbc_next = flush_i ? '0 : pbc_q;
        hunting  = (base_cnt == '0);
`endif
        for (int i = 0; i < RETIRE_W; i++) begin
            append_lane = valid_i[i];
`ifdef BRANCH_PREDICT_EN
            // Skip correctly predicted branches only while nothing has been
            // appended yet. The first mispredict ends the skipping.
            if (valid_i[i] && hunting) begin
                if (taken_i[i] == predict_i[i]) begin
                    append_lane = 1'b0;
                    if (pbc_next != '1) begin
                        pbc_next = pbc_next + PBC_W'(1);
                    end
                end else begin
                    hunting = 1'b0;
                end
            end
`endif
            if (append_lane) begin
                ext_map[sum_cnt] = ~taken_i[i];
                sum_cnt = sum_cnt + (CNT_W+1)'(1);
            end
        end

        // Once the map reaches MAP_LEN bits, the low MAP_LEN bits form the
        // snapshot and the spill-over bits become the new live map.
        complete = (sum_cnt >= (CNT_W+1)'(MAP_LEN));
        if (complete) begin
            next_map = MAP_LEN'(ext_map >> MAP_LEN);
            next_cnt = CNT_W'(sum_cnt - (CNT_W+1)'(MAP_LEN));
        end else begin
            next_map = ext_map[MAP_LEN-1:0];
            next_cnt = CNT_W'(sum_cnt);
        end

        // The buffer can take a new snapshot if it is empty or is being drained.
        accept = !full_valid_q || full_ready_i;
    end

    // Live map state and the hand-off buffer. A snapshot completed while the
    // buffer is still held is lost, and the loss is recorded in overflow.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            map_q        <= '0;
            cnt_q        <= '0;
            empty_q      <= 1'b1;
            full_valid_q <= 1'b0;
            full_map_q   <= '0;
            overflow_q   <= 1'b0;
        end else begin
            map_q   <= next_map;
            cnt_q   <= next_cnt;
            empty_q <= (next_cnt == '0);

            if (complete && accept) begin
                full_valid_q <= 1'b1;
                full_map_q   <= ext_map[MAP_LEN-1:0];
            end else if (full_valid_q && full_ready_i) begin
                full_valid_q <= 1'b0;
            end

            if (complete && !accept) begin
                overflow_q <= 1'b1;
            end else if (flush_i) begin
                overflow_q <= 1'b0;
            end
        end
    end

`ifdef BRANCH_PREDICT_EN
    // Predicted-branch counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pbc_q <= '0;
        end else begin
            pbc_q <= pbc_next;
        end
    end

    assign pbc_o = pbc_q;
`endif

    assign map_o        = map_q;
    assign branches_o   = cnt_q;
    assign empty_o      = empty_q;
    assign full_valid_o = full_valid_q;
    assign full_map_o   = full_map_q;
    assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_trdb_branch_map_mr.sv
// ---------------------------------------------------------------------------
// tb_trdb_branch_map_mr
// Directed, table-driven bench for trdb_branch_map_mr (MAP_LEN=31, RETIRE_W=2)
// plus hand-written sequences for asynchronous reset and branch prediction.
// ---------------------------------------------------------------------------
module tb_trdb_branch_map_mr;

    localparam int MAP_LEN  = 31;
    localparam int RETIRE_W = 2;
    localparam int PBC_W    = 16;
    localparam int CNT_W    = $clog2(MAP_LEN + 1);

    logic                clk_i = 1'b0;
    logic                rst_i;
    logic [RETIRE_W-1:0] valid_i;
    logic [RETIRE_W-1:0] taken_i;
    logic                flush_i;
    logic [MAP_LEN-1:0]  map_o;
    logic [CNT_W-1:0]    branches_o;
    logic                empty_o;
    logic                full_valid_o;
    logic [MAP_LEN-1:0]  full_map_o;
    logic                full_ready_i;
    logic                overflow_o;
`ifdef BRANCH_PREDICT_EN
    logic [RETIRE_W-1:0] predict_i;
    logic [PBC_W-1:0]    pbc_o;
`endif

    trdb_branch_map_mr #(
        .MAP_LEN  (MAP_LEN),
        .RETIRE_W (RETIRE_W),
        .PBC_W    (PBC_W)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .valid_i      (valid_i),
        .taken_i      (taken_i),
`ifdef BRANCH_PREDICT_EN
        .predict_i    (predict_i),
        .pbc_o        (pbc_o),
`endif
        .flush_i      (flush_i),
        .map_o        (map_o),
        .branches_o   (branches_o),
        .empty_o      (empty_o),
        .full_valid_o (full_valid_o),
        .full_map_o   (full_map_o),
        .full_ready_i (full_ready_i),
        .overflow_o   (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  valid;
        logic [1:0]  taken;
        logic        flush;
        logic        ready;
        int          exp_cnt;
        logic [30:0] exp_map;
        logic        exp_fv;
        logic [30:0] exp_fmap;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[$];
    int   total  = 0;
    int   passed = 0;

    task automatic addRow(input logic [1:0] v, input logic [1:0] t, input logic f,
                          input logic r, input int cnt, input logic [30:0] m,
                          input logic fv, input logic [30:0] fm, input logic ovf);
        vec_t row;
        row.valid = v;   row.taken = t;  row.flush = f;  row.ready = r;
        row.exp_cnt = cnt; row.exp_map = m; row.exp_fv = fv;
        row.exp_fmap = fm; row.exp_ovf = ovf;
        vecs.push_back(row);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Drive one cycle of inputs, then sample just after the active edge.
    task automatic applyStimulus(input logic [1:0] v, input logic [1:0] t,
                                 input logic f, input logic r);
        valid_i      = v;
        taken_i      = t;
        flush_i      = f;
        full_ready_i = r;
`ifdef BRANCH_PREDICT_EN
        predict_i    = ~t;
`endif
        @(posedge clk_i);
        #1;
    endtask

`ifdef BRANCH_PREDICT_EN
    task automatic applyPredict(input logic [1:0] v, input logic [1:0] t,
                                input logic [1:0] p);
        valid_i      = v;
        taken_i      = t;
        predict_i    = p;
        flush_i      = 1'b0;
        full_ready_i = 1'b0;
        @(posedge clk_i);
        #1;
    endtask
`endif

    initial begin
        logic [30:0] m;

        // Rows 0..14: pairs (lane0 taken, lane1 not taken) build 10 repeated.
        m = '0;
        for (int k = 0; k < 15; k++) begin
            m = m | (31'(2) << (2 * k));
            addRow(2'b11, 2'b01, 0, 0, 2 * (k + 1), m, 0, '0, 0);
        end
        // Row 15: count 30 plus two not-taken branches completes the map.
        addRow(2'b11, 2'b00, 0, 0, 1, 31'h1, 1, 31'h6AAAAAAA, 0);
        // Rows 16..29: refill with taken branches while the buffer is held.
        for (int j = 1; j <= 14; j++)
            addRow(2'b11, 2'b11, 0, 0, 1 + 2 * j, 31'h1, 1, 31'h6AAAAAAA, 0);
        // Row 30: second full map is dropped; buffer unchanged.
        addRow(2'b11, 2'b11, 0, 0, 0, 31'h0, 1, 31'h6AAAAAAA, 1);
        // Row 31: flush clears overflow, leaves the buffer alone.
        addRow(2'b00, 2'b00, 1, 0, 0, 31'h0, 1, 31'h6AAAAAAA, 0);
        addRow(2'b01, 2'b00, 0, 0, 1, 31'h1, 1, 31'h6AAAAAAA, 0);
        // Row 33: emitter drains the buffer.
        addRow(2'b00, 2'b00, 0, 1, 1, 31'h1, 0, '0, 0);
        // Rows 34..41: grow to 17 branches.
        for (int j = 1; j <= 8; j++)
            addRow(2'b11, 2'b11, 0, 0, 1 + 2 * j, 31'h1, 0, '0, 0);
        // Row 42: flush with only lane 1 valid lands at bit 0.
        addRow(2'b10, 2'b00, 1, 0, 1, 31'h1, 0, '0, 0);
        // Rows 43..57: fill to a map whose only set bit is bit 0.
        for (int j = 1; j <= 14; j++)
            addRow(2'b11, 2'b11, 0, 0, 1 + 2 * j, 31'h1, 0, '0, 0);
        addRow(2'b11, 2'b11, 0, 0, 0, 31'h0, 1, 31'h1, 0);
        // Rows 58..72: refill to 30 with the buffer held.
        for (int j = 1; j <= 15; j++)
            addRow(2'b11, 2'b11, 0, 0, 2 * j, 31'h0, 1, 31'h1, 0);
        // Row 73: completes while the buffer is drained the same cycle.
        addRow(2'b01, 2'b00, 0, 1, 0, 31'h0, 1, 31'h40000000, 0);
        addRow(2'b00, 2'b00, 0, 1, 0, 31'h0, 0, '0, 0);

        rst_i = 1'b1;
        valid_i = '0; taken_i = '0; flush_i = 1'b0; full_ready_i = 1'b0;
`ifdef BRANCH_PREDICT_EN
        predict_i = '0;
`endif
        #12;
        checkOutput("reset map", 32'(map_o), 32'h0);
        checkOutput("reset branches", 32'(branches_o), 32'h0);
        checkOutput("reset empty", 32'(empty_o), 32'h1);
        checkOutput("reset full_valid", 32'(full_valid_o), 32'h0);
        checkOutput("reset full_map", 32'(full_map_o), 32'h0);
        checkOutput("reset overflow", 32'(overflow_o), 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].valid, vecs[i].taken, vecs[i].flush, vecs[i].ready);
            checkOutput($sformatf("row%0d branches", i), 32'(branches_o), 32'(vecs[i].exp_cnt));
            checkOutput($sformatf("row%0d map", i), 32'(map_o), 32'(vecs[i].exp_map));
            checkOutput($sformatf("row%0d empty", i), 32'(empty_o), 32'(vecs[i].exp_cnt == 0));
            checkOutput($sformatf("row%0d full_valid", i), 32'(full_valid_o), 32'(vecs[i].exp_fv));
            checkOutput($sformatf("row%0d overflow", i), 32'(overflow_o), 32'(vecs[i].exp_ovf));
            if (vecs[i].exp_fv)
                checkOutput($sformatf("row%0d full_map", i), 32'(full_map_o), 32'(vecs[i].exp_fmap));
`ifdef BRANCH_PREDICT_EN
            checkOutput($sformatf("row%0d pbc", i), 32'(pbc_o), 32'h0);
`endif
        end

        // Asynchronous reset in the middle of a cycle clears state at once.
        applyStimulus(2'b11, 2'b00, 0, 0);
        applyStimulus(2'b11, 2'b00, 0, 0);
        checkOutput("pre-reset branches", 32'(branches_o), 32'h4);
        #3;
        rst_i = 1'b1;
        #1;
        checkOutput("async reset map", 32'(map_o), 32'h0);
        checkOutput("async reset branches", 32'(branches_o), 32'h0);
        checkOutput("async reset empty", 32'(empty_o), 32'h1);
        @(negedge clk_i);
        rst_i = 1'b0;

`ifdef BRANCH_PREDICT_EN
        // Five correct predictions are counted, then a lane-1 mispredict appends.
        for (int i = 0; i < 5; i++) applyPredict(2'b01, 2'b00, 2'b00);
        checkOutput("pbc after 5", 32'(pbc_o), 32'h5);
        checkOutput("branches after 5", 32'(branches_o), 32'h0);
        applyPredict(2'b11, 2'b00, 2'b10);
        checkOutput("pbc after mispredict", 32'(pbc_o), 32'h6);
        checkOutput("branches after mispredict", 32'(branches_o), 32'h1);
        checkOutput("map after mispredict", 32'(map_o), 32'h1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
